// File: rtl/radio_init_ctrl.sv
// radio_init_ctrl: waits for chip-ready on MISO, soft-resets the radio, streams the
// config ROM as address/value byte pairs, then issues SRX; retries on ready timeouts.
module radio_init_ctrl #(
    parameter int CFG_COUNT   = 47,
    parameter int RDY_TIMEOUT = 48000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        CLK_48MHZ,
    input  logic        BUF2_PBRST_T9,
    input  logic        MISO,
    output logic        ss_req,
    output logic        xfer_start,
    output logic [7:0]  xfer_data,
    output logic        xfer_last,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic [5:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        init_done,
    output logic        init_error,
    output logic [7:0]  status_last
);
    localparam int CW = $clog2(RDY_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RDY_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [5:0] IDX_LAST = 6'(CFG_COUNT - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY1, SRES, WAIT_RDY2, FETCH, WR_ADDR, WR_DATA, STROBE, DONE, ERROR
    } state_t;

    state_t state, state_n;
    logic [1:0] miso_sync;
    logic miso_s, phase, gap, waiting, xfer_state, timeout, done_ok;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [5:0] index;
    logic [15:0] cfg_reg;

    assign miso_s = miso_sync[1];
    // gap is the single SS-released cycle between a timeout and the next ready wait
    assign waiting = (state == WAIT_RDY1 || state == WAIT_RDY2) && !gap;
    assign timeout = waiting && miso_s && cnt == CNT_LAST;
    assign xfer_state = state inside {SRES, WR_ADDR, WR_DATA, STROBE};
    // phase is low only on a state's entry cycle, so it marks "byte already started"
    assign done_ok = xfer_state && phase && xfer_done;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = WAIT_RDY1;
            WAIT_RDY1, WAIT_RDY2:
                if (waiting && !miso_s) state_n = state == WAIT_RDY1 ? SRES : FETCH;
                else if (timeout) state_n = retry == RETRY_LAST ? ERROR : WAIT_RDY1;
            SRES:    if (done_ok) state_n = WAIT_RDY2;
            FETCH:   if (phase) state_n = WR_ADDR;
            WR_ADDR: if (done_ok) state_n = WR_DATA;
            WR_DATA: if (done_ok) state_n = index == IDX_LAST ? STROBE : FETCH;
            STROBE:  if (done_ok) state_n = DONE;
            default: state_n = state;
        endcase
    end

    always_comb begin
        ss_req = waiting && miso_s;
        xfer_start = xfer_state && !phase;
        xfer_data = state == SRES ? 8'h30 :
                    state == WR_ADDR ? cfg_reg[15:8] & 8'h3f :
                    state == WR_DATA ? cfg_reg[7:0] :
                    state == STROBE ? 8'h34 : 8'h00;
        xfer_last = state inside {SRES, WR_DATA, STROBE};
        cfg_addr = index;
        init_done = state == DONE;
        init_error = state == ERROR;
    end

    always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
        if (!BUF2_PBRST_T9) begin
            state <= IDLE;
            miso_sync <= 2'b11;
            phase <= 1'b0;
            gap <= 1'b0;
            cnt <= '0;
            retry <= '0;
            index <= '0;
            cfg_reg <= '0;
            status_last <= '0;
        end else begin
            state <= state_n;
            miso_sync <= {miso_sync[0], MISO};
            phase <= state_n == state;
            gap <= timeout && state_n == WAIT_RDY1;
            cnt <= (waiting && state_n == state && !timeout) ? cnt + 1'b1 : '0;
            retry <= timeout ? retry + 1'b1 : retry;
            if (state == FETCH && phase) cfg_reg <= cfg_data;
            if (state == WR_DATA && done_ok) index <= index + 1'b1;
            if (xfer_done) status_last <= xfer_rx;
        end
    end
endmodule

// File: tb/tb_radio_init_ctrl.sv
// tb_radio_init_ctrl: random ROM and status bytes, a 16-cycle byte master model and an
// SS-window monitor, checked against the byte stream derived from the ROM contents.
module tb_radio_init_ctrl;
    localparam int CFG = 47, TMO = 100, RET = 3;

    logic clk = 0, rst_n = 1, MISO = 1, xfer_done = 0;
    logic ss_req, xfer_start, xfer_last, init_done, init_error;
    logic [7:0] xfer_data, status_last, xfer_rx = 0;
    logic [5:0] cfg_addr;
    logic [15:0] cfg_data = 0;
    logic [15:0] rom [64];

    int n_chk = 0, n_fail = 0;
    logic [8:0] bytes_q [$];
    int done_cnt = 0, viol = 0, spur_cnt = 0;
    logic [7:0] spur_val = 0, last_rx = 0;
    int miso_after = 0;
    bit miso_hi = 0;
    int falls = 0;
    int wins [$];
    int gaps [$];

    typedef struct {
        int n;
        bit done;
        bit err;
        int tmo;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    radio_init_ctrl #(.CFG_COUNT(CFG), .RDY_TIMEOUT(TMO), .MAX_RETRY(RET)) dut (
        .CLK_48MHZ(clk), .BUF2_PBRST_T9(rst_n), .MISO(MISO), .ss_req(ss_req),
        .xfer_start(xfer_start), .xfer_data(xfer_data), .xfer_last(xfer_last),
        .xfer_done(xfer_done), .xfer_rx(xfer_rx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .init_done(init_done), .init_error(init_error), .status_last(status_last)
    );

    always_ff @(posedge clk) cfg_data <= rom[cfg_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // byte master: 16-cycle transfers, random status byte, protocol watch
    initial begin : master
        int seen;
        logic [7:0] d;
        logic l;
        seen = 0;
        forever begin
            if (!rst_n) begin
                last_rx = 0;
                xfer_done = 0;
            end
            if (rst_n && spur_cnt != seen) begin
                seen = spur_cnt;
                xfer_rx = spur_val;
                xfer_done = 1;
                @(posedge clk); #1;
                xfer_done = 0;
                last_rx = spur_val;
            end else if (rst_n && xfer_start) begin
                d = xfer_data;
                l = xfer_last;
                bytes_q.push_back({l, d});
                for (int k = 0; k < 15; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) break;
                    if (xfer_start || xfer_data !== d || xfer_last !== l) viol++;
                end
                if (rst_n) begin
                    xfer_rx = 8'($urandom);
                    xfer_done = 1;
                    @(posedge clk); #1;
                    xfer_done = 0;
                    last_rx = xfer_rx;
                    done_cnt++;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // SS monitor: records ss_req high-window and gap lengths, drives MISO
    initial begin : mon
        int run, lowrun;
        logic prev;
        run = 0; lowrun = 0; prev = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                falls = 0; run = 0; lowrun = 0; prev = 0;
                wins.delete();
                gaps.delete();
            end else begin
                if (ss_req && !prev && falls > 0) gaps.push_back(lowrun);
                if (!ss_req && prev) begin
                    wins.push_back(run);
                    falls++;
                end
                if (ss_req && !prev) run = 0;
                if (!ss_req && prev) lowrun = 0;
                if (ss_req) run++; else lowrun++;
                prev = ss_req;
            end
            MISO = miso_hi || falls < miso_after;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_end();
        int c;
        c = 0;
        while (!(init_done || init_error) && c < 8000) begin
            @(negedge clk);
            c++;
        end
        chk("end_reached", c < 8000, 1);
    endtask

    task automatic chk_stream(input int base);
        logic [8:0] e [$];
        e.push_back({1'b1, 8'h30});
        for (int i = 0; i < CFG; i++) begin
            e.push_back({1'b0, 2'b00, rom[i][13:8]});
            e.push_back({1'b1, rom[i][7:0]});
        end
        e.push_back({1'b1, 8'h34});
        chk("stream_len", bytes_q.size() - base, e.size());
        for (int i = 0; i < e.size() && base + i < bytes_q.size(); i++)
            chk($sformatf("byte%0d", i), bytes_q[base + i], e[i]);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ss_req"}, ss_req, 0);
        chk({tag, "_xfer_start"}, xfer_start, 0);
        chk({tag, "_xfer_data"}, xfer_data, 0);
        chk({tag, "_xfer_last"}, xfer_last, 0);
        chk({tag, "_cfg_addr"}, cfg_addr, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_init_error"}, init_error, 0);
        chk({tag, "_status_last"}, status_last, 0);
    endtask

    initial begin : main
        int base, base2, c, dc, sz;
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        rom[5] = 16'h0B06;
        vecs[0] = '{0, 1'b1, 1'b0, 0};
        vecs[1] = '{1, 1'b1, 1'b0, 1};
        vecs[2] = '{2, 1'b1, 1'b0, 2};
        vecs[3] = '{255, 1'b0, 1'b1, 3};
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk_reset_outs("por");
        rst_n = 1;

        for (int t = 0; t < 4; t++) begin
            miso_after = vecs[t].n;
            miso_hi = 0;
            do_reset();
            base = bytes_q.size();
            wait_end();
            chk($sformatf("v%0d_done", t), init_done, vecs[t].done);
            chk($sformatf("v%0d_error", t), init_error, vecs[t].err);
            chk($sformatf("v%0d_win_count", t), wins.size() >= vecs[t].tmo, 1);
            for (int j = 0; j < vecs[t].tmo && j < wins.size(); j++)
                chk($sformatf("v%0d_win%0d_len", t, j), wins[j], TMO);
            for (int j = 0; j < vecs[t].tmo - 1 && j < gaps.size(); j++)
                chk($sformatf("v%0d_gap%0d_len", t, j), gaps[j], 1);
            if (vecs[t].err) chk($sformatf("v%0d_win_exact", t), wins.size(), RET);
            if (vecs[t].done) chk_stream(base);
            else chk($sformatf("v%0d_no_xfer", t), bytes_q.size() - base, 0);
            repeat (30) @(negedge clk);
            chk($sformatf("v%0d_done_sticky", t), init_done, vecs[t].done);
            chk($sformatf("v%0d_error_sticky", t), init_error, vecs[t].err);
            chk($sformatf("v%0d_ss_idle", t), ss_req, 0);
            chk($sformatf("v%0d_status_last", t), status_last, last_rx);
            chk($sformatf("v%0d_protocol", t), viol, 0);
        end

        // entry 5: cfg_addr held across the fetch and both writes
        miso_after = 0;
        do_reset();
        base = bytes_q.size();
        c = 0;
        while (cfg_addr != 6'd5 && c < 3000) begin @(negedge clk); c++; end
        chk("addr5_reached", c < 3000, 1);
        chk("addr5_bytes_before", bytes_q.size() - base, 11);
        c = 0;
        while (cfg_addr == 6'd5 && c < 3000) begin @(negedge clk); c++; end
        chk("addr5_bytes_after", bytes_q.size() - base, 13);
        if (bytes_q.size() - base >= 13) begin
            chk("entry5_addr_byte", bytes_q[base + 11], {1'b0, 8'h0B});
            chk("entry5_value_byte", bytes_q[base + 12], {1'b1, 8'h06});
        end
        wait_end();
        chk("addr5_done", init_done, 1);

        // reset during the value byte of entry 10
        do_reset();
        base = bytes_q.size();
        c = 0;
        while (bytes_q.size() - base < 23 && c < 3000) begin @(negedge clk); c++; end
        chk("entry10_value_reached", c < 3000, 1);
        if (bytes_q.size() - base >= 23)
            chk("entry10_value_byte", bytes_q[base + 22], {1'b1, rom[10][7:0]});
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        chk_reset_outs("async");
        sz = bytes_q.size();
        repeat (3) @(negedge clk);
        chk("no_start_in_reset", bytes_q.size(), sz);
        rst_n = 1;
        base2 = bytes_q.size();
        c = 0;
        while (bytes_q.size() == base2 && c < 500) begin @(negedge clk); c++; end
        chk("restart_byte_seen", c < 500, 1);
        if (bytes_q.size() > base2) chk("restart_first_byte", bytes_q[base2], {1'b1, 8'h30});
        wait_end();
        chk_stream(base2);

        // spurious xfer_done while waiting for ready after SRES
        do_reset();
        base = bytes_q.size();
        c = 0;
        while (bytes_q.size() == base && c < 500) begin @(negedge clk); c++; end
        miso_hi = 1;
        dc = done_cnt;
        c = 0;
        while (done_cnt == dc && c < 500) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        chk("wait2_ss_req", ss_req, 1);
        spur_val = 8'hA5;
        spur_cnt++;
        repeat (3) @(negedge clk);
        chk("spur_status_last", status_last, 8'hA5);
        chk("spur_ss_req_kept", ss_req, 1);
        chk("spur_no_start", bytes_q.size() - base, 1);
        chk("spur_cfg_addr", cfg_addr, 0);
        miso_hi = 0;
        wait_end();
        chk("spur_done", init_done, 1);
        chk_stream(base);
        chk("final_protocol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
